// File: rtl/fec_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fec_pkg
//  Description : Shared constants and unrolled LFSR helpers for the
//                Clause 74 (2112,2080) FEC encoder.
//  Revision    : 1.0 - initial multilane release
// ============================================================================
package fec_pkg;

    localparam int          FEC_BLOCK_BITS   = 2112;
    localparam int          FEC_PAYLOAD_BITS = 2080;
    localparam int          FEC_PARITY_BITS  = 32;

    // g(x) = x^32 + x^23 + x^21 + x^11 + x^2 + 1, x^32 term implicit
    localparam logic [31:0] FEC_PARITY_POLY  = 32'h00A00805;

    // PN-2112 generator load value applied at word 0 of every block
    localparam logic [57:0] FEC_PN_SEED      = 58'h3FF_FFFF_FFFF_FFFF;

    // Advance the parity LFSR by 'width' bits; data bit 0 enters first.
    function automatic logic [31:0] parity_step(input logic [31:0] state,
                                                input logic [31:0] data,
                                                input int          width);
        logic [31:0] s;
        logic        fb;
        s = state;
        for (int i = 0; i < 32; i++) begin
            if (i < width) begin
                fb = s[31] ^ data[i];
                s  = {s[30:0], 1'b0} ^ (fb ? FEC_PARITY_POLY : 32'h0);
            end
        end
        return s;
    endfunction

    // Advance the x^58+x^39+1 generator by 'width' output bits.
    function automatic logic [57:0] pn_step(input logic [57:0] state,
                                            input int          width);
        logic [57:0] s;
        logic        b;
        s = state;
        for (int i = 0; i < 32; i++) begin
            if (i < width) begin
                b = s[57] ^ s[38];
                s = {s[56:0], b};
            end
        end
        return s;
    endfunction

    // The 'width' PN bits produced from 'state'; bit 0 is the first in time.
    function automatic logic [31:0] pn_bits(input logic [57:0] state,
                                            input int          width);
        logic [57:0] s;
        logic [31:0] m;
        logic        b;
        s = state;
        m = '0;
        for (int i = 0; i < 32; i++) begin
            if (i < width) begin
                b    = s[57] ^ s[38];
                m[i] = b;
                s    = {s[56:0], b};
            end
        end
        return m;
    endfunction

endpackage : fec_pkg
`default_nettype wire

// File: rtl/fec_lane_enc.sv
`default_nettype none
// ============================================================================
//  Module      : fec_lane_enc
//  Description : One FEC lane: parity LFSR, PN-2112 scrambler and the
//                registered output word mux (data / parity / bypass).
//  Revision    : 1.0 - initial multilane release
// ============================================================================
module fec_lane_enc
    import fec_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int SCRAMBLE   = 1
) (
    input  logic                  clk,
    input  logic                  arst,
    input  logic                  clear,      // abort block: zero LFSR, reload PN
    input  logic                  load,       // an output word is produced this cycle
    input  logic                  blk_start,  // current word is word 0 of a block
    input  logic                  par_sel,    // current word is a parity word
    input  logic                  byp_sel,    // current word is a raw pass-through
    input  logic [1:0]            par_idx,    // which parity word of the block
    input  logic [DATA_WIDTH-1:0] din,
    output logic [DATA_WIDTH-1:0] dout
);

    logic [31:0]           lfsr_q, lfsr_d;
    logic [57:0]           pn_q, pn_d;
    logic [DATA_WIDTH-1:0] dout_q, dout_d;

    // Block start restarts both generators without needing an extra cycle.
    logic [31:0]           lfsr_base;
    logic [57:0]           pn_base;
    logic [31:0]           scr_mask;
    logic [DATA_WIDTH-1:0] scr;
    logic [31:0]           par_rev;
    logic [31:0]           par_shift;
    logic [DATA_WIDTH-1:0] par_word;

    assign lfsr_base = blk_start ? 32'h0 : lfsr_q;
    assign pn_base   = blk_start ? FEC_PN_SEED : pn_q;
    assign scr_mask  = (SCRAMBLE != 0) ? pn_bits(pn_base, DATA_WIDTH) : 32'h0;
    assign scr       = scr_mask[DATA_WIDTH-1:0];
    assign par_shift = par_rev >> (DATA_WIDTH * int'(par_idx));
    assign par_word  = par_shift[DATA_WIDTH-1:0];

    // Bit-reverse the LFSR so the MSB lands on the first transmitted bit.
    always_comb begin
        par_rev = '0;
        for (int k = 0; k < 32; k++) begin
            par_rev[k] = lfsr_q[31-k];
        end
    end

    // Next-state selection for LFSR, scrambler and output word.
    always_comb begin
        lfsr_d = lfsr_q;
        pn_d   = pn_q;
        dout_d = dout_q;
        if (clear) begin
            lfsr_d = 32'h0;
            pn_d   = FEC_PN_SEED;
        end else if (load) begin
            if (byp_sel) begin
                dout_d = din;
            end else if (par_sel) begin
                dout_d = par_word ^ scr;
                pn_d   = pn_step(pn_base, DATA_WIDTH);
            end else begin
                lfsr_d = parity_step(lfsr_base, 32'(din), DATA_WIDTH);
                dout_d = din ^ scr;
                pn_d   = pn_step(pn_base, DATA_WIDTH);
            end
        end
    end

    // Lane state registers.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            lfsr_q <= 32'h0;
            pn_q   <= FEC_PN_SEED;
            dout_q <= '0;
        end else begin
            lfsr_q <= lfsr_d;
            pn_q   <= pn_d;
            dout_q <= dout_d;
        end
    end

    assign dout = dout_q;

endmodule : fec_lane_enc
`default_nettype wire

// File: rtl/fec_enc_multilane.sv
`default_nettype none
// ============================================================================
//  Module      : fec_enc_multilane
//  Description : NUM_LANES-wide Clause 74 (2112,2080) FEC encoder with shared
//                block framing, flow control, restart and bypass control.
//  Revision    : 1.0 - initial multilane release
// ============================================================================
module fec_enc_multilane
    import fec_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_LANES  = 1,
    parameter int SCRAMBLE   = 1
) (
    input  logic                            clk,
    input  logic                            arst,
    input  logic                            restart,
    input  logic                            bypass,
    input  logic [NUM_LANES*DATA_WIDTH-1:0] din,
    input  logic                            din_valid,
    output logic                            din_ready,
    output logic [NUM_LANES*DATA_WIDTH-1:0] dout,
    output logic                            dout_valid,
    output logic                            dout_sop,
    output logic                            dout_parity,
    output logic                            bypass_active
);

    localparam int WPB   = FEC_BLOCK_BITS / DATA_WIDTH;
    localparam int DW    = FEC_PAYLOAD_BITS / DATA_WIDTH;
    localparam int CNT_W = $clog2(WPB);

    localparam logic [CNT_W-1:0] DW_C   = CNT_W'(DW);
    localparam logic [CNT_W-1:0] LAST_C = CNT_W'(WPB - 1);

    // Only widths dividing both the payload and the parity field are usable.
    if (!(DATA_WIDTH == 8 || DATA_WIDTH == 16 || DATA_WIDTH == 32)) begin : g_bad_width
        $error("fec_enc_multilane: DATA_WIDTH must be 8, 16 or 32");
    end

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             valid_q, valid_d;
    logic             sop_q, sop_d;
    logic             par_q, par_d;
    logic             byp_q, byp_d;

    logic             blk_start;
    logic             data_ph;
    logic             par_ph;
    logic             bypass_now;
    logic             accept;
    logic             load;
    logic [1:0]       par_idx;

    assign blk_start  = (cnt_q == '0);
    assign data_ph    = (cnt_q < DW_C);
    assign par_ph     = !data_ph;
    assign bypass_now = blk_start && bypass;
    assign din_ready  = !restart && data_ph;
    assign accept     = din_valid && din_ready;
    assign load       = !restart && (par_ph || accept);
    assign par_idx    = 2'(cnt_q - DW_C);

    // Block framing counter and output flag generation.
    always_comb begin
        cnt_d   = cnt_q;
        valid_d = load;
        sop_d   = load && blk_start && !bypass_now;
        par_d   = load && par_ph;
        byp_d   = !restart && bypass_now;
        if (restart) begin
            cnt_d = '0;
        end else if (par_ph) begin
            cnt_d = (cnt_q == LAST_C) ? '0 : cnt_q + 1'b1;
        end else if (accept && !bypass_now) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Shared control registers.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            cnt_q   <= '0;
            valid_q <= 1'b0;
            sop_q   <= 1'b0;
            par_q   <= 1'b0;
            byp_q   <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
            sop_q   <= sop_d;
            par_q   <= par_d;
            byp_q   <= byp_d;
        end
    end

    for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
        fec_lane_enc #(
            .DATA_WIDTH (DATA_WIDTH),
            .SCRAMBLE   (SCRAMBLE)
        ) u_lane (
            .clk       (clk),
            .arst      (arst),
            .clear     (restart),
            .load      (load),
            .blk_start (blk_start),
            .par_sel   (par_ph),
            .byp_sel   (bypass_now),
            .par_idx   (par_idx),
            .din       (din[l*DATA_WIDTH +: DATA_WIDTH]),
            .dout      (dout[l*DATA_WIDTH +: DATA_WIDTH])
        );
    end

    assign dout_valid    = valid_q;
    assign dout_sop      = sop_q;
    assign dout_parity   = par_q;
    assign bypass_active = byp_q;

endmodule : fec_enc_multilane
`default_nettype wire

// File: tb/tb_fec_enc_multilane.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fec_enc_multilane
//  Description : Randomised bench for fec_enc_multilane (16-bit, 4 lanes)
//                against a block-level reference built from polynomial
//                long division and the PN-2112 recurrence.
//  Revision    : 1.0 - initial multilane release
// ============================================================================
module tb_fec_enc_multilane;

    localparam int TW  = 16;
    localparam int TL  = 4;
    localparam int OW  = TW * TL;
    localparam int BLK = 2112;
    localparam int PAY = 2080;
    localparam int WPB = BLK / TW;
    localparam int DWN = PAY / TW;
    localparam logic [57:0] TB_SEED = 58'h3FF_FFFF_FFFF_FFFF;

    logic          clk = 1'b0;
    logic          arst;
    logic          restart;
    logic          bypass;
    logic [OW-1:0] din;
    logic          din_valid;
    logic          din_ready;
    logic [OW-1:0] dout;
    logic          dout_valid;
    logic          dout_sop;
    logic          dout_parity;
    logic          bypass_active;

    always #5 clk = ~clk;

    fec_enc_multilane #(
        .DATA_WIDTH (TW),
        .NUM_LANES  (TL),
        .SCRAMBLE   (1)
    ) dut (
        .clk           (clk),
        .arst          (arst),
        .restart       (restart),
        .bypass        (bypass),
        .din           (din),
        .din_valid     (din_valid),
        .din_ready     (din_ready),
        .dout          (dout),
        .dout_valid    (dout_valid),
        .dout_sop      (dout_sop),
        .dout_parity   (dout_parity),
        .bypass_active (bypass_active)
    );

    int n_cmp = 0;
    int n_err = 0;

    bit pn_seq [BLK];      // PN-2112 sequence, index = bit time in block
    bit cw     [TL][BLK];  // per-lane unscrambled codeword of current block
    bit lane_zero [TL];
    int pos;               // reference word position inside the block

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // x[n] = x[n-58] ^ x[n-39]; the seed supplies x[-1..-58].
    task automatic build_pn();
        bit ext [58+BLK];
        for (int k = 0; k < 58; k++) ext[57-k] = TB_SEED[k];
        for (int i = 0; i < BLK; i++) begin
            ext[i+58] = ext[i] ^ ext[i+19];
            pn_seq[i] = ext[i+58];
        end
    endtask

    // Remainder of M(x)*x^32 by g(x), via long division, first bit = top degree.
    task automatic compute_parity(input int l);
        bit a [BLK];
        int g_off [6];
        g_off = '{0, 9, 11, 21, 30, 32};
        for (int t = 0; t < BLK; t++) a[t] = (t < PAY) ? cw[l][t] : 1'b0;
        for (int i = 0; i < PAY; i++) begin
            if (a[i]) begin
                for (int k = 0; k < 6; k++) a[i+g_off[k]] ^= 1'b1;
            end
        end
        for (int t = PAY; t < BLK; t++) cw[l][t] = a[t];
    endtask

    function automatic logic [OW-1:0] word_at(input int p);
        logic [OW-1:0] w;
        for (int l = 0; l < TL; l++)
            for (int j = 0; j < TW; j++)
                w[l*TW+j] = cw[l][p*TW+j] ^ pn_seq[p*TW+j];
        return w;
    endfunction

    // One clock cycle: drive, predict, check handshake, clock, check outputs.
    task automatic step(input bit v, input bit rs, input bit by);
        logic [OW-1:0] d;
        logic [OW-1:0] nd;
        bit            exp_rdy, nv, nsop, npar, nbyp;
        for (int l = 0; l < TL; l++)
            d[l*TW +: TW] = lane_zero[l] ? '0 : TW'($urandom);
        din = d; din_valid = v; restart = rs; bypass = by;
        nd = '0; nv = 0; nsop = 0; npar = 0; nbyp = 0;
        #1;
        if (rs) begin
            exp_rdy = 0;
            pos     = 0;
        end else if (pos >= DWN) begin
            exp_rdy = 0;
            nv      = 1;
            npar    = 1;
            nd      = word_at(pos);
            pos     = (pos == WPB - 1) ? 0 : pos + 1;
        end else if (pos == 0 && by) begin
            exp_rdy = 1;
            nbyp    = 1;
            nv      = v;
            nd      = d;
        end else begin
            exp_rdy = 1;
            nv      = v;
            if (v) begin
                for (int l = 0; l < TL; l++)
                    for (int j = 0; j < TW; j++)
                        cw[l][pos*TW+j] = d[l*TW+j];
                nd   = word_at(pos);
                nsop = (pos == 0);
                pos++;
                if (pos == DWN)
                    for (int l = 0; l < TL; l++) compute_parity(l);
            end
        end
        chk("din_ready", din_ready, exp_rdy);
        @(posedge clk);
        #1;
        chk("dout_valid", dout_valid, nv);
        chk("bypass_active", bypass_active, nbyp);
        if (nv) begin
            chk("dout", dout, nd);
            chk("dout_sop", dout_sop, nsop);
            chk("dout_parity", dout_parity, npar);
        end
    endtask

    task automatic run_to(input int target);
        for (int i = 0; i < 2 * WPB && pos != target; i++) step(1'b1, 1'b0, 1'b0);
        chk("reach_pos", 128'(pos), 128'(target));
    endtask

    function automatic bit rnd_valid();
        return ($urandom_range(0, 9) >= 3);
    endfunction

    initial begin
        build_pn();
        pos = 0;
        for (int l = 0; l < TL; l++) lane_zero[l] = 0;
        arst = 1'b1; restart = 1'b0; bypass = 1'b0; din = '0; din_valid = 1'b0;
        #1;
        chk("rst_dout", dout, '0);
        chk("rst_valid", dout_valid, 1'b0);
        chk("rst_sop", dout_sop, 1'b0);
        chk("rst_parity", dout_parity, 1'b0);
        chk("rst_bypass", bypass_active, 1'b0);
        chk("rst_ready", din_ready, 1'b1);
        #11 arst = 1'b0;
        @(posedge clk);
        #1;

        // Gap-free blocks; lane 3 carries zeros so it shows the bare PN stream.
        lane_zero[3] = 1;
        for (int i = 0; i < 2 * WPB; i++) step(1'b1, 1'b0, 1'b0);
        lane_zero[3] = 0;

        // Roughly 30% idle input cycles.
        for (int i = 0; i < 4 * WPB; i++) step(rnd_valid(), 1'b0, 1'b0);

        // Abort at data word 40, then a clean block.
        run_to(0);
        run_to(40);
        step(1'b1, 1'b1, 1'b0);
        for (int i = 0; i < WPB + 3; i++) step(1'b1, 1'b0, 1'b0);

        // Abort inside the parity phase.
        run_to(DWN + 1);
        step(1'b1, 1'b1, 1'b0);
        for (int i = 0; i < WPB; i++) step(1'b1, 1'b0, 1'b0);

        // Bypass raised mid-block: block finishes, then raw pass-through.
        run_to(50);
        for (int i = 0; i < WPB + 40; i++) step(rnd_valid(), 1'b0, 1'b1);
        for (int i = 0; i < WPB + 5; i++) step(1'b1, 1'b0, 1'b0);

        // Asynchronous reset mid-block.
        run_to(70);
        din_valid = 1'b0; restart = 1'b0; bypass = 1'b0;
        #1 arst = 1'b1;
        #1;
        chk("arst_dout", dout, '0);
        chk("arst_valid", dout_valid, 1'b0);
        chk("arst_ready", din_ready, 1'b1);
        #1 arst = 1'b0;
        pos = 0;
        @(posedge clk);
        #1;
        chk("arst_idle_valid", dout_valid, 1'b0);
        for (int i = 0; i < WPB + 2; i++) step(1'b1, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_fec_enc_multilane
`default_nettype wire
